// File: rtl/weight_loader.sv
// Streams weight words into a layer's per-neuron weight memories.
// Each accepted word becomes a registered one-hot write to the current neuron at the current address.
module weight_loader #(
    parameter int unsigned numWeight    = 784,
    parameter int unsigned numNeuron    = 30,
    parameter int unsigned layerNo      = 1,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned dataWidth    = 16,
    parameter int unsigned neuronWidth  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [neuronWidth-1:0]  start_neuron,
    input  logic                    s_valid,
    input  logic [dataWidth-1:0]    s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [numNeuron-1:0]    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [addressWidth-1:0] addr_last   = addressWidth'(numWeight - 1);
    localparam logic [neuronWidth-1:0]  neuron_last = neuronWidth'(numNeuron - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [addressWidth-1:0] addr;
    logic [neuronWidth-1:0]  neuron;
    logic                    beat;
    logic                    last_addr;
    logic                    final_beat;
    logic                    start_ok;

    assign s_ready    = (state == LOAD);
    assign beat       = s_valid && s_ready;
    assign last_addr  = (addr == addr_last);
    assign final_beat = last_addr && (neuron == neuron_last);
    assign start_ok   = (32'(start_neuron) < numNeuron);

    // Write strobes and the done pulse default low; only a beat or the final beat raise them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= '0;
            neuron <= '0;
            wen    <= '0;
            wadd   <= '0;
            win    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            wen  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            state  <= LOAD;
                            busy   <= 1'b1;
                            neuron <= start_neuron;
                            addr   <= '0;
                            err    <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        wen  <= numNeuron'(1) << neuron;
                        wadd <= addr;
                        win  <= s_data;
                        // The sender's end marker must line up exactly with the final word.
                        if (s_last != final_beat) begin
                            err <= 1'b1;
                        end
                        if (final_beat) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (last_addr) begin
                            addr   <= '0;
                            neuron <= neuron + 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
